// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: UART receive endpoint that recovers frames from an
// asynchronous serial line directly on the system clock. It synchronises
// the line, validates the start bit at mid-bit, samples every following bit
// one bit period apart, and reports data, parity error and framing error.
module uart_rx_sampler (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_start,
    input  logic        rx,
    input  logic [16:0] baud,
    input  logic [3:0]  length,
    input  logic        parity_type,
    input  logic        parity_en,
    output logic [7:0]  rx_out,
    output logic        rx_done,
    output logic        rx_err,
    output logic        frame_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Even-parity (XOR reduction) of a data byte.
    function automatic logic parity8(input logic [7:0] d);
        return ^d;
    endfunction

    // Mask that keeps only the bits below the frame length.
    function automatic logic [7:0] len_mask(input logic [3:0] len);
        logic [7:0] m;
        m = 8'h00;
        for (int i = 0; i < 8; i++) begin
            m[i] = (i < int'(len));
        end
        return m;
    endfunction

    // Line synchroniser and edge detection
    logic        rx_meta_r;
    logic        rx_s_r;
    logic        rx_d_r;
    logic        fall_r;

    // FSM and datapath state
    state_t      state_r;
    state_t      state_s;
    logic [16:0] cnt_r;
    logic [16:0] cnt_s;
    logic [2:0]  bit_idx_r;
    logic [2:0]  bit_idx_s;
    logic [7:0]  shift_r;
    logic [7:0]  shift_s;
    logic        p_bit_r;
    logic        p_bit_s;
    logic        latch_s;
    logic        load_s;

    // Frame configuration captured when a frame starts
    logic [16:0] baud_l_r;
    logic [3:0]  len_l_r;
    logic        ptype_l_r;
    logic        pen_l_r;

    // Registered results
    logic [7:0]  rx_out_r;
    logic        rx_done_r;
    logic        rx_err_r;
    logic        frame_err_r;
    logic        busy_r;

    // Derived values
    logic [16:0] baud_cfg_s;
    logic [3:0]  len_cfg_s;
    logic [16:0] half_s;
    logic        bit_end_s;
    logic [2:0]  len_m1_s;
    logic [7:0]  data_s;
    logic        perr_s;

    assign baud_cfg_s = (baud < 17'd4) ? 17'd4 : baud;
    assign len_cfg_s  = (length < 4'd5) ? 4'd5 : ((length > 4'd8) ? 4'd8 : length);
    assign half_s     = baud_l_r >> 1;
    assign bit_end_s  = (cnt_r == (baud_l_r - 17'd1));
    assign len_m1_s   = 3'(len_l_r - 4'd1);
    assign data_s     = shift_r & len_mask(len_l_r);
    assign perr_s     = pen_l_r & (p_bit_r != (parity8(data_s) ^ ptype_l_r));

    // Two-flop synchroniser, delayed copy, and a registered falling-edge flag
    // (the flag is why START is entered three edges after rx is first seen low)
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta_r <= 1'b1;
            rx_s_r    <= 1'b1;
            rx_d_r    <= 1'b1;
            fall_r    <= 1'b0;
        end else begin
            rx_meta_r <= rx;
            rx_s_r    <= rx_meta_r;
            rx_d_r    <= rx_s_r;
            fall_r    <= rx_d_r & ~rx_s_r;
        end
    end

    // Next-state, bit counter and shift-register decisions for the receive FSM
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        bit_idx_s = bit_idx_r;
        shift_s   = shift_r;
        p_bit_s   = p_bit_r;
        latch_s   = 1'b0;
        load_s    = 1'b0;
        if (!rx_start) begin
            state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (fall_r) begin
                        state_s = S_START;
                        cnt_s   = 17'd0;
                        latch_s = 1'b1;
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_START: begin
                    if (cnt_r == half_s) begin
                        if (!rx_s_r) begin
                            state_s   = S_DATA;
                            cnt_s     = 17'd0;
                            bit_idx_s = 3'd0;
                        end else begin
                            state_s = S_IDLE;
                        end
                    end else begin
                        cnt_s = cnt_r + 17'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end_s) begin
                        shift_s[bit_idx_r] = rx_s_r;
                        cnt_s              = 17'd0;
                        if (bit_idx_r == len_m1_s) begin
                            state_s = pen_l_r ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx_s = bit_idx_r + 3'd1;
                        end
                    end else begin
                        cnt_s = cnt_r + 17'd1;
                    end
                end
                S_PARITY: begin
                    if (bit_end_s) begin
                        p_bit_s = rx_s_r;
                        cnt_s   = 17'd0;
                        state_s = S_STOP;
                    end else begin
                        cnt_s = cnt_r + 17'd1;
                    end
                end
                S_STOP: begin
                    if (bit_end_s) begin
                        load_s  = 1'b1;
                        cnt_s   = 17'd0;
                        state_s = S_IDLE;
                    end else begin
                        cnt_s = cnt_r + 17'd1;
                    end
                end
                default: begin
                    state_s = S_IDLE;
                end
            endcase
        end
    end

    // FSM state, counters and captured bits
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= S_IDLE;
            cnt_r     <= 17'd0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            p_bit_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
            p_bit_r   <= p_bit_s;
        end
    end

    // Frame configuration latch: sampled only as a frame starts
    always_ff @(posedge clk) begin
        if (!rst) begin
            baud_l_r  <= 17'd4;
            len_l_r   <= 4'd8;
            ptype_l_r <= 1'b0;
            pen_l_r   <= 1'b0;
        end else if (latch_s) begin
            baud_l_r  <= baud_cfg_s;
            len_l_r   <= len_cfg_s;
            ptype_l_r <= parity_type;
            pen_l_r   <= parity_en;
        end
    end

    // Result registers: all results update together with the rx_done pulse
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_out_r    <= 8'h00;
            rx_done_r   <= 1'b0;
            rx_err_r    <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            rx_done_r <= load_s;
            busy_r    <= (state_s != S_IDLE);
            if (load_s) begin
                rx_out_r    <= data_s;
                rx_err_r    <= perr_s;
                frame_err_r <= ~rx_s_r;
            end
        end
    end

    assign rx_out    = rx_out_r;
    assign rx_done   = rx_done_r;
    assign rx_err    = rx_err_r;
    assign frame_err = frame_err_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Testbench for uart_rx_sampler: a driver serialises frames onto rx and
// pushes the expected result (data, flags, completion cycle) into a queue;
// an independent monitor pops and compares on every rx_done.
`timescale 1ns/1ps
module tb_uart_rx_sampler;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_start;
    logic        rx;
    logic [16:0] baud;
    logic [3:0]  length;
    logic        parity_type;
    logic        parity_en;
    logic [7:0]  rx_out;
    logic        rx_done;
    logic        rx_err;
    logic        frame_err;
    logic        busy;

    uart_rx_sampler dut (
        .clk         (clk),
        .rst         (rst),
        .rx_start    (rx_start),
        .rx          (rx),
        .baud        (baud),
        .length      (length),
        .parity_type (parity_type),
        .parity_en   (parity_en),
        .rx_out      (rx_out),
        .rx_done     (rx_done),
        .rx_err      (rx_err),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       err;
        logic       ferr;
        int         when;
    } exp_t;

    localparam int HOOK_NONE  = 0;
    localparam int HOOK_ABORT = 1;
    localparam int HOOK_RESET = 2;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         compared   = 0;
    int         mismatched = 0;
    int         cyc        = 0;
    logic       rst_q      = 1'b0;
    logic [9:0] prev_res   = 10'd0;
    logic [7:0] last_out   = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Edge counter and the reset value each edge saw
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // Monitor: results must hold between rx_done pulses; each rx_done is
    // matched against the oldest expected frame
    always @(negedge clk) begin
        if (!rst_q) begin
            last_out = 8'h00;
        end else begin
            if (!rx_done) begin
                check("result_stable", 32'({rx_out, rx_err, frame_err}), 32'(prev_res));
            end
            if (rx_done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_rx_done", 32'(1), 32'(0));
                end else begin
                    mon_e = sb_q.pop_front();
                    check("rx_out",    32'(rx_out),    32'(mon_e.data));
                    check("rx_err",    32'(rx_err),    32'(mon_e.err));
                    check("frame_err", 32'(frame_err), 32'(mon_e.ferr));
                    check("done_cycle", 32'(cyc),      32'(mon_e.when));
                    last_out = mon_e.data;
                end
            end
        end
        prev_res = {rx_out, rx_err, frame_err};
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_drain"}, 32'(sb_q.size()), 32'(0));
    endtask

    // Serialise one frame. The line keeps the stop value for 'hold' cycles,
    // then idles high for 'idle' cycles. A hook can abort or reset mid-bit.
    task automatic send_frame(input logic [7:0] data, input logic [16:0] baud_raw,
                              input logic [3:0] len_raw, input logic pen, input logic ptype,
                              input logic flip, input logic stop_val, input int hold,
                              input int idle_n, input int hook_kind, input int hook_idx,
                              input logic expect_frame, input logic scramble);
        logic       bits[$];
        int         be;
        int         le;
        logic [8:0] mask9;
        logic [7:0] dm;
        logic       pbit;
        exp_t       e;
        be    = (baud_raw < 17'd4) ? 4 : int'(baud_raw);
        le    = (len_raw < 4'd5) ? 5 : ((len_raw > 4'd8) ? 8 : int'(len_raw));
        mask9 = (9'd1 << le) - 9'd1;
        dm    = data & mask9[7:0];
        pbit  = (^dm) ^ ptype ^ flip;
        baud        = baud_raw;
        length      = len_raw;
        parity_en   = pen;
        parity_type = ptype;
        bits.push_back(1'b0);
        for (int i = 0; i < le; i++) bits.push_back(dm[i]);
        if (pen) bits.push_back(pbit);
        bits.push_back(stop_val);
        if (expect_frame) begin
            e.data = dm;
            e.err  = pen & flip;
            e.ferr = ~stop_val;
            e.when = cyc + 1 + 4 + be / 2 + (le + int'(pen) + 1) * be;
            sb_q.push_back(e);
        end
        for (int b = 0; b < bits.size(); b++) begin
            rx = bits[b];
            if (scramble && b == 1) begin
                baud        = 17'($urandom_range(0, 40));
                length      = 4'($urandom_range(0, 15));
                parity_en   = 1'($urandom_range(0, 1));
                parity_type = 1'($urandom_range(0, 1));
            end
            for (int c = 0; c < be; c++) begin
                if (b == hook_idx && c == be / 2 && hook_kind == HOOK_ABORT) rx_start = 1'b0;
                if (b == hook_idx && c == be / 2 && hook_kind == HOOK_RESET) rst = 1'b0;
                @(posedge clk);
                #1;
                if (b == hook_idx && c == be / 2 && hook_kind == HOOK_RESET) begin
                    check("rst_rx_out",    32'(rx_out),    32'(0));
                    check("rst_rx_done",   32'(rx_done),   32'(0));
                    check("rst_rx_err",    32'(rx_err),    32'(0));
                    check("rst_frame_err", 32'(frame_err), 32'(0));
                    check("rst_busy",      32'(busy),      32'(0));
                    rst = 1'b1;
                end
            end
        end
        idle(hold);
        rx = 1'b1;
        idle(idle_n);
    endtask

    // Watchdog
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [16:0] br;
        logic [3:0]  lr;
        logic        pe;
        logic        sv;
        rst = 1'b0; rx_start = 1'b0; rx = 1'b1;
        baud = 17'd16; length = 4'd8; parity_type = 1'b0; parity_en = 1'b0;
        idle(4);
        check("reset_rx_out",    32'(rx_out),    32'(0));
        check("reset_rx_done",   32'(rx_done),   32'(0));
        check("reset_rx_err",    32'(rx_err),    32'(0));
        check("reset_frame_err", 32'(frame_err), 32'(0));
        check("reset_busy",      32'(busy),      32'(0));
        rst = 1'b1;
        rx_start = 1'b1;
        idle(20);

        // Basic 8N1
        send_frame(8'hA5, 17'd16, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 0, 16, HOOK_NONE, -1, 1'b1, 1'b0);
        wait_drain("basic");

        // 7-bit even parity, good then flipped parity bit
        send_frame(8'h3C, 17'd16, 4'd7, 1'b1, 1'b0, 1'b0, 1'b1, 0, 16, HOOK_NONE, -1, 1'b1, 1'b0);
        send_frame(8'h3C, 17'd16, 4'd7, 1'b1, 1'b0, 1'b1, 1'b1, 0, 16, HOOK_NONE, -1, 1'b1, 1'b0);
        wait_drain("parity");

        // 5-bit odd parity
        send_frame(8'h1F, 17'd16, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1, 0, 32, HOOK_NONE, -1, 1'b1, 1'b0);
        wait_drain("short_odd");

        // Start glitch: 3 low cycles, baud 16 (half = 8)
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(1);
        check("glitch_busy_high", 32'(busy), 32'(1));
        idle(9);
        check("glitch_busy_low", 32'(busy), 32'(0));
        idle(32);

        // Framing error followed by a stuck-low line
        send_frame(8'h55, 17'd16, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 64, 48, HOOK_NONE, -1, 1'b1, 1'b0);
        wait_drain("frame_err");
        check("stuck_frame_err_held", 32'(frame_err), 32'(1));
        check("stuck_rx_out_held",    32'(rx_out),    32'(8'h55));

        // Abort mid-DATA, then back-to-back frames
        send_frame(8'h6B, 17'd16, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 0, 32, HOOK_ABORT, 3, 1'b0, 1'b0);
        check("abort_rx_out_held", 32'(rx_out), 32'(last_out));
        check("abort_busy", 32'(busy), 32'(0));
        rx_start = 1'b1;
        idle(8);
        send_frame(8'h12, 17'd16, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, HOOK_NONE, -1, 1'b1, 1'b0);
        send_frame(8'h34, 17'd16, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 0, 32, HOOK_NONE, -1, 1'b1, 1'b0);
        wait_drain("back_to_back");

        // Reset during data bit 3 (bits 3..7 high so the line stays idle-high)
        send_frame({5'b11111, 3'($urandom_range(0, 7))}, 17'd16, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1,
                   0, 32, HOOK_RESET, 4, 1'b0, 1'b0);
        send_frame(8'h81, 17'd16, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 0, 32, HOOK_NONE, -1, 1'b1, 1'b0);
        wait_drain("after_reset");

        // Randomised frames with mid-frame configuration changes
        for (int k = 0; k < 16; k++) begin
            br = 17'($urandom_range(6, 24));
            lr = 4'($urandom_range(0, 15));
            pe = 1'($urandom_range(0, 1));
            sv = ($urandom_range(0, 4) != 0);
            send_frame(8'($urandom_range(0, 255)), br, lr, pe, 1'($urandom_range(0, 1)),
                       pe & 1'($urandom_range(0, 1)), sv,
                       sv ? 0 : int'($urandom_range(0, 40)),
                       sv ? int'($urandom_range(0, 2)) * int'(br) : int'(br),
                       HOOK_NONE, -1, 1'b1, 1'b1);
        end
        wait_drain("random");
        idle(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Standalone UART receive endpoint that takes an asynchronous serial line from an off-chip transmitter and recovers frames directly on the system clock. It needs no derived tx_clk/rx_clk. It complements the existing tx/rx pair by serving the external-facing end of the link. It shares that pair's frame controls (baud, length, parity_type, parity_en) and result outputs (rx_out, rx_done, rx_err), so the existing UVM scoreboard can check it unchanged. It adds line synchronisation, mid-bit sampling, start-glitch rejection and framing-error detection.

## Interface
- No parameters. Widths are fixed to match the existing UART blocks.
- clk  input  1  system clock. Single clock domain.
- rst  input  1  synchronous, active-low reset.
- rx_start  input  1  receive enable. 0 means idle, and any in-flight frame is aborted.
- rx  input  1  asynchronous serial line. Idles high.
- baud  input  17  clk cycles per bit period. Values below 4 are treated as 4.
- length  input  4  data bits per frame, 5..8. Values below 5 are treated as 5; values above 8 are treated as 8.
- parity_type  input  1  0 = even, 1 = odd.
- parity_en  input  1  1 = a parity bit follows the data bits.
- rx_out  output  8  last received data, LSB-first assembled, zero-extended above length.
- rx_done  output  1  one-cycle pulse when a frame completes.
- rx_err  output  1  parity mismatch on the last frame. Valid with rx_done, held until the next rx_done.
- frame_err  output  1  stop bit sampled low on the last frame. Valid with rx_done, held until the next rx_done.
- busy  output  1  high in every state except IDLE.

## Operation
- **Synchroniser.** rx passes through 2 flops to give rx_s, and rx_s is delayed one more flop to give rx_d.
- **Configuration latch.** baud, length, parity_type and parity_en are latched on the IDLE->START transition. Changes mid-frame are ignored.
- **Counters.**
  - cnt is 17 bits and counts clk cycles within a bit.
  - bit_idx is 3 bits.
  - half = baud_l >> 1.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **IDLE.** If rx_start=1 and rx_d=1 and rx_s=0 (falling edge): set cnt=0 and go to START.
- **START.** cnt increments each cycle. At cnt==half:
  - if rx_s=0, set cnt=0, bit_idx=0 and go to DATA;
  - otherwise it is a glitch: return to IDLE with no outputs changed.
- **DATA.** At cnt==baud_l-1:
  - set shift[bit_idx]=rx_s and cnt=0;
  - if bit_idx==length_l-1, go to PARITY when parity_en_l=1, otherwise go to STOP;
  - otherwise increment bit_idx.
- **PARITY.** At cnt==baud_l-1, capture rx_s as p_bit and go to STOP.
- **STOP.** At cnt==baud_l-1, register all results together and go to IDLE:
  - rx_out = shift with bits at index length_l and above forced to 0;
  - rx_err = parity_en_l & (p_bit != (^data ^ parity_type));
  - frame_err = ~rx_s;
  - rx_done=1 for exactly one cycle.
- **Break / stuck-low line.** After a framing error the line may stay low. A new frame requires a fresh high-to-low edge, so a stuck-low line produces no further frames.
- **rx_start falling mid-frame.** Go to IDLE at the next edge. No rx_done is issued, and rx_out, rx_err and frame_err keep their previous values.
- **Reset (rst=0 at a clk edge).**
  - Outputs: rx_out=0, rx_done=0, rx_err=0, frame_err=0, busy=0.
  - Internal: FSM=IDLE, cnt=0, bit_idx=0, shift=0, and the synchroniser flops are set to 1.
  - Reset takes effect mid-frame as well. A frame interrupted by reset is lost.

## Timing
- **Edge to START.** Let edge E0 be the first clk edge that samples rx low. The FSM enters START at edge E0+3.
- **Start validation.** The start bit is validated at edge E0+3+half+1.
- **Sample spacing.** Each subsequent sample is taken exactly baud_l cycles after the previous one, which places it at mid-bit.
- **rx_done timing.** rx_done is high in the cycle following edge E0+4+half+N·baud_l, where N = length_l + parity_en_l + 1.
- **Output stability.** rx_out, rx_err and frame_err change only on the same edge that raises rx_done.
- **busy.** busy rises with START and falls when the FSM returns to IDLE.
- **Back-to-back frames.** A falling edge arriving in the cycle after the FSM returns to IDLE is accepted. Frames with a single stop bit can therefore be received back-to-back with no gap.
- **Tolerance.** The tolerated line rate error is ±(half−2)/(N·baud_l + half) of the bit period.

## Test plan
- **Basic 8N1 frame.** Settings: baud=16, length=8, parity_en=0; send 0xA5 with 1 stop bit. Expect rx_out=0xA5, rx_done for 1 cycle at the cycle given by the Timing formula, rx_err=0, frame_err=0.
- **Parity.** Settings: length=7, parity_en=1, parity_type=0; send 0x3C with correct even parity, then 0x3C with the parity bit flipped. Expect rx_out=0x3C both times, with rx_err=0 on the first frame and rx_err=1 on the second.
- **Short frame, odd parity, zero-extension.** Settings: length=5, parity_type=1; send 0x1F. Expect rx_out=0x1F with upper bits 0 and rx_err=0.
- **Glitch and framing error.**
  - Drive rx low for 3 cycles with baud=16: expect busy to pulse high, then return to IDLE with no rx_done.
  - Send 0x55 with the stop bit low: expect rx_done=1 and frame_err=1, and no second frame while the line stays low.
- **Abort and back-to-back.**
  - Drop rx_start mid-DATA: expect no rx_done and rx_out unchanged.
  - Then send 0x12 and 0x34 back-to-back: expect two rx_done pulses with rx_out=0x12 then 0x34.
- **Reset mid-frame.** Assert rst=0 for 1 cycle during bit 3 of a frame. Expect all outputs to be 0 on the following cycle, no rx_done for that frame, and the next full frame 0x81 received correctly.
